// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the
// I2C slave with register memory.
package i2c_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    DEV_ADDR = 4'd1,
    RW       = 4'd2,
    ACK_DEV  = 4'd3,
    MEM_ADDR = 4'd4,
    ACK_MEM  = 4'd5,
    RD_DATA  = 4'd6,
    WR_DATA  = 4'd7,
    ACK_DATA = 4'd8
  } state_t;

endpackage

// File: rtl/i2c_slave_with_mem_if.sv
// i2c_slave_with_mem_if: open-drain SCL/SDA bus.
// SDA is a wired-AND of both pull-downs over a pull-up.
interface i2c_slave_with_mem_if;

  logic SCL;
  logic m_sda_low;
  logic s_sda_low;
  logic SDA;

  // Released line floats high via the pull-up
  assign SDA = ~(m_sda_low | s_sda_low);

  modport master (
    output SCL,
    output m_sda_low,
    input  s_sda_low,
    input  SDA
  );

  modport slave (
    input  SCL,
    input  SDA,
    output s_sda_low
  );

endinterface

// File: rtl/i2c_mem.sv
// i2c_mem: DEPTH x DW register file, synchronous
// write, combinational read, reloadable pattern.
module i2c_mem #(
  parameter  int DEPTH = 256,
  parameter  int DW    = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write port; memory is never touched by reset
  always @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

  task automatic initiate();
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] <= DW'(i);
    end
    mem[1] <= DW'(8'h05);
  endtask

endmodule

// File: rtl/i2c_slave_with_mem.sv
// i2c_slave_with_mem: oversampled I2C-style slave
// doing one single-byte read or write per transfer.
module i2c_slave_with_mem
  import i2c_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int DW    = DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  i2c_slave_with_mem_if.slave bus,
  input  logic [ADDR_W-1:0] id,
  output logic [3:0]        state,
  output logic [DW-1:0]     data_buffer
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_q;
  logic       sda_q;
  logic       scl;
  logic       sda;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  bit_cnt;
  logic        last_bit;
  logic [ADDR_W-1:0] addr_buf;
  logic [ADDR_W-1:0] mem_addr;
  logic        rw;
  logic        dev_hit;
  logic        sda_low;
  logic        sda_low_d;
  logic        we;
  logic [DW-1:0] rdata;

  assign scl = scl_sync[1];
  assign sda = sda_sync[1];

  assign scl_rise  = scl & ~scl_q;
  assign scl_fall  = ~scl & scl_q;
  assign start_det = scl & scl_q & sda_q & ~sda;
  assign stop_det  = scl & scl_q & ~sda_q & sda;

  assign last_bit = (bit_cnt == 3'd7);
  assign dev_hit  = (addr_buf == id);

  assign state         = state_q;
  assign bus.s_sda_low = sda_low;

  // Two-stage synchronizers plus edge history;
  // reset to the idle-high bus level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], bus.SCL};
      sda_sync <= {sda_sync[0], bus.SDA};
      scl_q    <= scl_sync[1];
      sda_q    <= sda_sync[1];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state on SCL rise; SDA drive on SCL fall
  always_comb begin
    state_d   = state_q;
    sda_low_d = sda_low;
    unique case (1'b1)
      start_det: begin
        state_d   = DEV_ADDR;
        sda_low_d = 1'b0;
      end
      stop_det: begin
        state_d   = IDLE;
        sda_low_d = 1'b0;
      end
      scl_rise: begin
        case (state_q)
          DEV_ADDR: if (last_bit) state_d = RW;
          RW:       state_d = ACK_DEV;
          ACK_DEV:  state_d = dev_hit ? MEM_ADDR : IDLE;
          MEM_ADDR: if (last_bit) state_d = ACK_MEM;
          ACK_MEM:  state_d = (rw == READ) ? RD_DATA
                                           : WR_DATA;
          RD_DATA:  if (last_bit) state_d = ACK_DATA;
          WR_DATA:  if (last_bit) state_d = ACK_DATA;
          ACK_DATA: state_d = IDLE;
          default:  state_d = state_q;
        endcase
      end
      scl_fall: begin
        case (state_q)
          ACK_DEV:  sda_low_d = dev_hit;
          ACK_MEM:  sda_low_d = 1'b1;
          RD_DATA:  sda_low_d = ~data_buffer[DW-1];
          ACK_DATA: sda_low_d = (rw == WRITE);
          default:  sda_low_d = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  // Shifters, bit counter, SDA driver, write strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt     <= '0;
      addr_buf    <= '0;
      mem_addr    <= '0;
      rw          <= WRITE;
      data_buffer <= '0;
      sda_low     <= 1'b0;
      we          <= 1'b0;
    end else begin
      we      <= 1'b0;
      sda_low <= sda_low_d;
      unique case (1'b1)
        start_det, stop_det: bit_cnt <= '0;
        scl_rise: begin
          case (state_q)
            DEV_ADDR: begin
              addr_buf <= {addr_buf[ADDR_W-2:0], sda};
              bit_cnt  <= bit_cnt + 3'd1;
            end
            RW: rw <= sda;
            MEM_ADDR: begin
              mem_addr <= {mem_addr[ADDR_W-2:0], sda};
              bit_cnt  <= bit_cnt + 3'd1;
            end
            ACK_MEM: begin
              if (rw == READ) data_buffer <= rdata;
            end
            RD_DATA: begin
              data_buffer <= {data_buffer[DW-2:0],
                              data_buffer[DW-1]};
              bit_cnt     <= bit_cnt + 3'd1;
            end
            WR_DATA: begin
              data_buffer <= {data_buffer[DW-2:0], sda};
              bit_cnt     <= bit_cnt + 3'd1;
              if (last_bit) we <= 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  i2c_mem #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (mem_addr),
    .wdata (data_buffer),
    .raddr (mem_addr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_i2c_slave_with_mem.sv
// tb_i2c_slave_with_mem: bit-banged bus master with
// table, hand-written and random transfers.
module tb_i2c_slave_with_mem;
  import i2c_pkg::*;

  localparam int TQ = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] id;
  logic [3:0] state;
  logic [7:0] data_buffer;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] ref_mem [256];

  typedef struct {
    logic [7:0] dev;
    logic [7:0] idv;
    logic       rd;
    logic [7:0] ma;
    logic [7:0] wd;
    logic       mack;
    logic       hit;
    logic [7:0] erd;
  } vec_t;

  vec_t tbl [10];

  i2c_slave_with_mem_if bus ();

  i2c_slave_with_mem dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .id          (id),
    .state       (state),
    .data_buffer (data_buffer)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input string what,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s %s: got %0h, expected %0h",
                  tag, what, act, exp);
  endtask

  task automatic bus_start();
    #TQ bus.m_sda_low = 1'b0;
    #TQ bus.SCL = 1'b1;
    #TQ bus.m_sda_low = 1'b1;
    #TQ bus.SCL = 1'b0;
    #TQ;
  endtask

  task automatic bus_stop();
    #TQ bus.m_sda_low = 1'b1;
    #TQ bus.SCL = 1'b1;
    #TQ bus.m_sda_low = 1'b0;
    #TQ;
  endtask

  task automatic bit_io(input logic b, output logic r);
    #TQ bus.m_sda_low = ~b;
    #TQ bus.SCL = 1'b1;
    #TQ r = bus.SDA;
    #TQ bus.SCL = 1'b0;
  endtask

  task automatic byte_write(input logic [7:0] b,
                            output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(b[i], r);
    bit_io(1'b1, ack);
  endtask

  task automatic byte_read(input logic mack,
                           output logic [7:0] d);
    logic r;
    d = '0;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, r);
      d[i] = r;
    end
    bit_io(mack, r);
  endtask

  task automatic send_hdr(input logic [7:0] dev,
                          input logic rd,
                          output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(dev[i], r);
    bit_io(rd, r);
    bit_io(1'b1, ack);
  endtask

  task automatic xfer(input logic [7:0] dev,
                      input logic rd,
                      input logic [7:0] ma,
                      input logic [7:0] wd,
                      input logic mack,
                      output logic a1, output logic a2,
                      output logic a3,
                      output logic [7:0] rdv,
                      output logic [3:0] st_end);
    a2 = 1'b1;
    a3 = 1'b1;
    rdv = '0;
    bus_start();
    send_hdr(dev, rd, a1);
    if (!a1) begin
      byte_write(ma, a2);
      if (rd) byte_read(mack, rdv);
      else    byte_write(wd, a3);
    end
    st_end = state;
    bus_stop();
  endtask

  task automatic do_txn(input string tag, input vec_t v);
    logic a1, a2, a3;
    logic [7:0] rdv;
    logic [3:0] st_end;
    id = v.idv;
    xfer(v.dev, v.rd, v.ma, v.wd, v.mack,
         a1, a2, a3, rdv, st_end);
    check(tag, "ack_dev", 32'(a1), 32'(!v.hit));
    if (v.hit) begin
      check(tag, "ack_mem", 32'(a2), 32'(0));
      if (v.rd) check(tag, "rdata", 32'(rdv), 32'(v.erd));
      else      check(tag, "ack_data", 32'(a3), 32'(0));
    end
    check(tag, "state_end", 32'(st_end), 32'(IDLE));
    if (v.hit && !v.rd) ref_mem[v.ma] = v.wd;
    check(tag, "mem", 32'(dut.u_mem.mem[v.ma]),
          32'(ref_mem[v.ma]));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic a;
    logic r;
    logic [3:0] nib;
    logic [7:0] d;
    vec_t v;

    reset = 1'b0;
    bus.SCL = 1'b1;
    bus.m_sda_low = 1'b0;
    id = 8'h01;
    dut.u_mem.initiate();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i);
    ref_mem[1] = 8'h05;

    tbl[0] = '{8'h01, 8'h01, 1'b1, 8'h01, 8'h00, 1'b0, 1'b1, 8'h05};
    tbl[1] = '{8'h01, 8'h01, 1'b0, 8'h02, 8'h7F, 1'b0, 1'b1, 8'h00};
    tbl[2] = '{8'h01, 8'h01, 1'b1, 8'h02, 8'h00, 1'b0, 1'b1, 8'h7F};
    tbl[3] = '{8'h02, 8'h01, 1'b1, 8'h03, 8'h00, 1'b0, 1'b0, 8'h00};
    tbl[4] = '{8'h01, 8'h01, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00};
    tbl[5] = '{8'h01, 8'h01, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b1, 8'h00};
    tbl[6] = '{8'h01, 8'h01, 1'b0, 8'h10, 8'hFF, 1'b0, 1'b1, 8'h00};
    tbl[7] = '{8'h01, 8'h01, 1'b1, 8'h10, 8'h00, 1'b0, 1'b1, 8'hFF};
    tbl[8] = '{8'h81, 8'h01, 1'b0, 8'h04, 8'hAA, 1'b0, 1'b0, 8'h00};
    tbl[9] = '{8'hA5, 8'hA5, 1'b1, 8'h03, 8'h00, 1'b0, 1'b1, 8'h03};

    #(4*TQ);
    check("reset", "state", 32'(state), 32'(IDLE));
    check("reset", "data_buffer", 32'(data_buffer), 32'(0));
    check("reset", "sda_drive", 32'(bus.s_sda_low), 32'(0));
    check("reset", "sda_line", 32'(bus.SDA), 32'(1));
    reset = 1'b1;
    #(2*TQ);

    for (int i = 0; i < 10; i++) do_txn($sformatf("tbl%0d", i), tbl[i]);

    // repeated start in the middle of the memory address
    id = 8'h01;
    bus_start();
    send_hdr(8'h01, 1'b1, a);
    check("rstart", "ack_dev", 32'(a), 32'(0));
    for (int i = 0; i < 4; i++) bit_io(1'b0, r);
    bus_start();
    check("rstart", "state", 32'(state), 32'(DEV_ADDR));
    check("rstart", "bit_cnt", 32'(dut.bit_cnt), 32'(0));
    send_hdr(8'h01, 1'b1, a);
    check("rstart", "ack_dev2", 32'(a), 32'(0));
    byte_write(8'h03, a);
    check("rstart", "ack_mem", 32'(a), 32'(0));
    byte_read(1'b0, d);
    check("rstart", "rdata", 32'(d), 32'(ref_mem[3]));
    bus_stop();
    check("rstart", "state_end", 32'(state), 32'(IDLE));

    // reset asserted while the slave drives a read byte
    v = '{8'h01, 8'h01, 1'b0, 8'h02, 8'h70, 1'b0, 1'b1, 8'h00};
    do_txn("wr70", v);
    bus_start();
    send_hdr(8'h01, 1'b1, a);
    byte_write(8'h02, a);
    nib = '0;
    for (int i = 3; i >= 0; i--) begin
      bit_io(1'b1, r);
      nib[i] = r;
    end
    check("rst_mid", "bits", 32'(nib), 32'(4'b0111));
    #TQ;
    check("rst_mid", "sda_bit4", 32'(bus.SDA), 32'(0));
    check("rst_mid", "state_rd", 32'(state), 32'(RD_DATA));
    reset = 1'b0;
    #1;
    check("rst_mid", "sda_drive", 32'(bus.s_sda_low), 32'(0));
    check("rst_mid", "state", 32'(state), 32'(IDLE));
    check("rst_mid", "data_buffer", 32'(data_buffer), 32'(0));
    #(TQ-1);
    bus.SCL = 1'b1;
    #TQ;
    reset = 1'b1;
    #(2*TQ);
    check("rst_mid", "mem2", 32'(dut.u_mem.mem[2]),
          32'(ref_mem[2]));

    // STOP after five data bits of a write
    bus_start();
    send_hdr(8'h01, 1'b0, a);
    check("stop_wr", "ack_dev", 32'(a), 32'(0));
    byte_write(8'h20, a);
    check("stop_wr", "ack_mem", 32'(a), 32'(0));
    d = 8'hAA;
    for (int i = 7; i >= 3; i--) bit_io(d[i], r);
    bus_stop();
    check("stop_wr", "state", 32'(state), 32'(IDLE));
    check("stop_wr", "mem20", 32'(dut.u_mem.mem[8'h20]),
          32'(ref_mem[8'h20]));

    // random transfers against the memory model
    for (int i = 0; i < 24; i++) begin
      v.idv  = 8'($urandom);
      v.dev  = ($urandom_range(1, 0) == 1) ? v.idv :
               (v.idv ^ (8'h01 << $urandom_range(7, 0)));
      v.rd   = 1'($urandom);
      v.ma   = 8'($urandom);
      v.wd   = 8'($urandom);
      v.mack = 1'($urandom);
      v.hit  = (v.dev == v.idv);
      v.erd  = ref_mem[v.ma];
      do_txn($sformatf("rnd%0d", i), v);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
